// File: rtl/seg7_pkg.sv
// Shared constants for the stopwatch seven-segment scan driver.
// Contents: active-low segment codes {g,f,e,d,c,b,a}, the anode-off pattern,
// the digit-index-to-anode table, and the scan FSM state encoding.
package seg7_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Indexed by digit position: [3]=minutes (leftmost) .. [0]=tenths
  localparam logic [3:0][3:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern; values above 9 show a dash.
// Ports: bcd (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a}, active-low out).
// Purely combinational, no latency.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed M.SS.T driver for a 4-digit common-anode display.
// Ports: tick/clr (clock, sync active-high reset), min/secmsd/seclsd/ten (BCD digits),
// blank_lz (suppress a zero minute digit), an/seg/dp (active-low pins, registered, 1-cycle latency).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       tick,
  input  logic       clr,
  input  logic [3:0] min,
  input  logic [3:0] secmsd,
  input  logic [3:0] seclsd,
  input  logic [3:0] ten,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_ACT  = CW'(BLANK_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;

  logic [3:0] snap_min, snap_secmsd, snap_seclsd, snap_ten;
  logic       snap_blank_lz;

  logic       frame_start;
  logic [3:0] digit;
  logic [6:0] dec_seg;
  logic       lz_blank;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  // Slot sequencing: idx steps down and wraps 0->3 on its own 2-bit width.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      idx_nxt   = idx - 2'd1;
      state_nxt = ST_BLANK;
    end else if (state == ST_BLANK && cnt == CNT_ACT) begin
      state_nxt = ST_ACTIVE;
    end
  end

  always_ff @(posedge tick) begin
    if (clr) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= 2'd3;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // All four digits are captured together so a frame never mixes two counter values.
  assign frame_start = (state == ST_BLANK) && (idx == 2'd3) && (cnt == '0);

  always_ff @(posedge tick) begin
    if (clr) begin
      snap_min      <= '0;
      snap_secmsd   <= '0;
      snap_seclsd   <= '0;
      snap_ten      <= '0;
      snap_blank_lz <= 1'b0;
    end else if (frame_start) begin
      snap_min      <= min;
      snap_secmsd   <= secmsd;
      snap_seclsd   <= seclsd;
      snap_ten      <= ten;
      snap_blank_lz <= blank_lz;
    end
  end

  always_comb begin
    digit = snap_ten;
    case (idx)
      2'd3: digit = snap_min;
      2'd2: digit = snap_secmsd;
      2'd1: digit = snap_seclsd;
      default: digit = snap_ten;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd(digit),
    .seg(dec_seg)
  );

  assign lz_blank = (idx == 2'd3) && snap_blank_lz && (snap_min == 4'd0);

  // Decimal points follow the minute and seconds-units digits (M.SS.T): idx 3 and 1.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state == ST_ACTIVE && !lz_blank) begin
      an_nxt  = AN_TABLE[idx];
      seg_nxt = dec_seg;
      dp_nxt  = ~idx[0];
    end
  end

  always_ff @(posedge tick) begin
    if (clr) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with a small slot/frame timing.
// The driver pushes the expected pin state for each clock edge; the monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic       tick;
  logic       clr;
  logic [3:0] min, secmsd, seclsd, ten;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .tick(tick), .clr(clr), .min(min), .secmsd(secmsd), .seclsd(seclsd),
    .ten(ten), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
  );

  initial tick = 1'b0;
  always #5 tick = ~tick;

  // Expected {an, seg, dp} per edge, plus the model position for diagnostics
  logic [11:0] exp_q[$];
  int          pos_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: position within the frame, and the digits captured at frame start
  int         pos = 0;
  logic [3:0] m_digit [4];
  logic       m_lz = 1'b0;
  logic [6:0] seg_code [16];

  initial begin
    seg_code[0] = 7'b1000000; seg_code[1] = 7'b1111001;
    seg_code[2] = 7'b0100100; seg_code[3] = 7'b0110000;
    seg_code[4] = 7'b0011001; seg_code[5] = 7'b0010010;
    seg_code[6] = 7'b0000010; seg_code[7] = 7'b1111000;
    seg_code[8] = 7'b0000000; seg_code[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_code[i] = 7'b0111111;
    for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
  end

  function automatic logic [11:0] model_out(input int p);
    int         slot_pos;
    int         d;
    logic [3:0] a;
    slot_pos = p % RD;
    d = 3 - ((p / RD) % 4);
    if (slot_pos < BC) return {4'b1111, 7'b1111111, 1'b1};
    if (d == 3 && m_lz && m_digit[3] == 4'd0) return {4'b1111, 7'b1111111, 1'b1};
    a = 4'b1111;
    a[d] = 1'b0;
    return {a, seg_code[m_digit[d]], (d == 3 || d == 1) ? 1'b0 : 1'b1};
  endfunction

  task automatic step(input logic c, input logic [3:0] m, input logic [3:0] s1,
                      input logic [3:0] s0, input logic [3:0] t, input logic lz);
    logic [11:0] e;
    @(negedge tick);
    clr = c; min = m; secmsd = s1; seclsd = s0; ten = t; blank_lz = lz;
    if (c) begin
      e = {4'b1111, 7'b1111111, 1'b1};
      pos_q.push_back(-1);
      pos = 0;
      for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
      m_lz = 1'b0;
    end else begin
      e = model_out(pos);
      pos_q.push_back(pos);
      if (pos % FRAME == 0) begin
        m_digit[3] = m; m_digit[2] = s1; m_digit[1] = s0; m_digit[0] = t;
        m_lz = lz;
      end
      pos++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare pins shortly after every edge that has an expectation queued
  initial begin
    logic [11:0] e;
    int          p;
    forever begin
      @(posedge tick);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        p = pos_q.pop_front();
        vectors++;
        if ({an, seg, dp} !== e) begin
          miscompares++;
          $display("FAIL pins pos=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   p, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] rm, r1, r0, rt;
    logic       rlz;
    int         guard;
    clr = 1'b1; min = 4'd0; secmsd = 4'd0; seclsd = 4'd0; ten = 4'd0; blank_lz = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));

    // Basic scan of 1.23.4 over two frames
    for (int i = 0; i < 2 * FRAME + 4; i++) step(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);

    // Mid-frame input change must not reach the display until the next frame
    step(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++)
      step(1'b0, 4'd1, 4'd2, (i < 5) ? 4'd3 : 4'd7, 4'd4, 1'b0);

    // Invalid digits decode as a dash
    for (int i = 0; i < FRAME; i++) step(1'b0, 4'd9, 4'd5, 4'd8, 4'hA, 1'b0);
    for (int i = 0; i < FRAME; i++) step(1'b0, 4'hC, 4'd0, 4'd6, 4'hF, 1'b0);

    // Leading-zero suppression, then a nonzero minute
    for (int i = 0; i < FRAME; i++) step(1'b0, 4'd0, 4'd4, 4'd2, 4'd1, 1'b1);
    for (int i = 0; i < FRAME; i++) step(1'b0, 4'd5, 4'd4, 4'd2, 4'd1, 1'b1);
    for (int i = 0; i < FRAME; i++) step(1'b0, 4'd0, 4'd4, 4'd2, 4'd1, 1'b0);

    // Reset in the middle of the idx-2 active window, then restart from frame start
    step(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < RD + BC + 2; i++) step(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    step(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < FRAME + 8; i++) step(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);

    // Random traffic: inputs wander freely, occasional resets
    rm = 4'd0; r1 = 4'd0; r0 = 4'd0; rt = 4'd0; rlz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        rm = 4'($urandom_range(11)); r1 = 4'($urandom_range(15));
        r0 = 4'($urandom_range(10)); rt = 4'($urandom_range(15));
        rlz = 1'($urandom);
        if ($urandom_range(2) == 0) rm = 4'd0;
      end
      step(($urandom_range(199) == 0) ? 1'b1 : 1'b0, rm, r1, r0, rt, rlz);
    end

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge tick);
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
